pack_rr_sched: RTL and testbench
================================

PACK_RR_SCHED -- requirements
Module: pack_rr_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter BYTES, default 4, meaning bytes packed per output word (fixed 4 for 32-bit out).
REQ-003 The block SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester byte valid.
REQ-006 The block SHALL have port req_data  input  8*NREQ  lane i = bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready  output  NREQ  per-requester byte accept.
REQ-008 The block SHALL have port data_out  output  32  packed word.
REQ-009 The block SHALL have port out_valid  output  1  data_out/out_src valid.
REQ-010 The block SHALL have port out_ready  input  1  downstream accept.
REQ-011 The block SHALL have port out_src  output  clog2(NREQ)  requester index owning data_out.
REQ-012 The block SHALL have port clk1x_en  output  1  one-cycle strobe per word transfer (out_valid & out_ready).

Function
REQ-013 The FSM SHALL use states IDLE, COLLECT and EMIT.
REQ-014 In IDLE with any req_valid high, the block SHALL grant one requester, latch grant index, clear byte count, and enter COLLECT next cycle.
REQ-015 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NREQ; after reset, search starts at index 0.
REQ-016 In COLLECT, req_ready SHALL be high only for the granted lane; all other bits SHALL be 0 in every state.
REQ-017 A byte SHALL transfer on req_valid[g] & req_ready[g]; each byte SHALL shift in MSB-first (first byte lands in data_out[31:24], fourth byte in [7:0]).
REQ-018 Grant SHALL be word-atomic: a deasserted req_valid[g] mid-word SHALL stall COLLECT with no timeout and no regrant.
REQ-019 On the BYTES-th beat the block SHALL register the word into data_out, set out_src = g, and enter EMIT.
REQ-020 In EMIT, out_valid SHALL be 1 and data_out/out_src SHALL hold stable until out_ready.
REQ-021 On out_valid & out_ready, clk1x_en SHALL pulse for exactly that cycle, last_grant SHALL update to g, and the FSM SHALL return to IDLE.
REQ-022 Minimum throughput SHALL be one word per 6 cycles (1 IDLE + 4 COLLECT + 1 EMIT, out_ready held high).
REQ-023 Requests arriving in EMIT SHALL be ignored until IDLE.
REQ-024 The byte counter SHALL be 2 bits and SHALL wrap 3->0 on word completion.
REQ-025 When only one requester is active, it SHALL be granted for every consecutive word.

Reset
REQ-026 While rst_n=0, the FSM SHALL be IDLE, and req_ready, out_valid and clk1x_en SHALL be 0.
REQ-027 While rst_n=0, data_out SHALL be 32'h0, out_src 0, the byte counter 0, and last_grant NREQ-1.
REQ-028 A reset mid-word SHALL discard partial bytes with no output; the first post-reset grant SHALL go to the lowest-indexed valid requester.

Structure
REQ-029 Package pack_sched_pkg SHALL hold the state enum (IDLE/COLLECT/EMIT), BYTES_PER_WORD=4 and WORD_W=32.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and last_grant; outputs grant index and any_req), purely combinational.

Verification
REQ-031 Single requester: lane0 sends 8'h11,22,33,44 -> data_out=32'h11223344, out_src=0, clk1x_en one pulse, 6 cycles from first valid.
REQ-032 All 4 lanes valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0; no lane is granted twice before all others.
REQ-033 Lane2 drops valid after 2 bytes for 5 cycles, lane1 valid throughout -> no regrant; word from lane2 completes correctly, then lane3 or next valid lane after 2 is served.
REQ-034 out_ready held low 10 cycles in EMIT -> data_out/out_src stable, req_ready all 0, clk1x_en 0 until out_ready=1, then one pulse.
REQ-035 rst_n asserted after 3 bytes of a word -> all outputs at reset values immediately; no word emitted; after release, lane0 is granted first if valid.
REQ-036 NREQ=2 build, both valid -> strict alternation 0,1,0,1.

Source files
------------

// File: rtl/pack_sched_pkg.sv
// Shared types and constants for the round-robin byte-packing scheduler.
package pack_sched_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first requester after i_last_grant, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last_grant,
    output logic [IW-1:0]   o_grant,
    output logic            o_any_req
);

    localparam int unsigned N = NREQ;

    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_idx     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = IW'((32'(i_last_grant) + k) % N);
            if (!o_any_req && i_req[w_idx]) begin
                o_any_req = 1'b1;
                o_grant   = w_idx;
            end
        end
    end

endmodule

// File: rtl/pack_rr_sched.sv
// Packs four bytes from one round-robin-granted requester into a 32-bit word.
module pack_rr_sched
    import pack_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int BYTES = 4,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [WORD_W-1:0]   data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW-1:0]       out_src,
    output logic                clk1x_en
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IW-1:0]       r_grant;
    logic [IW-1:0]       r_last;
    logic [1:0]          r_cnt;
    logic [WORD_W-9:0]   r_shift;
    logic [WORD_W-1:0]   r_data;
    logic [IW-1:0]       r_src;

    logic [IW-1:0]       w_arb_grant;
    logic                w_any_req;
    logic [7:0]          w_byte;
    logic                w_beat;
    logic                w_last_beat;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last),
        .o_grant      (w_arb_grant),
        .o_any_req    (w_any_req)
    );

    always_comb begin
        w_byte = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_grant == IW'(i)) w_byte = req_data[8*i +: 8];
        end
    end

    assign w_beat      = (r_state == COLLECT) && req_valid[r_grant];
    assign w_last_beat = w_beat && (r_cnt == 2'(BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        out_valid   = 1'b0;
        clk1x_en    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_state_nxt = COLLECT;
            end
            COLLECT: begin
                req_ready[r_grant] = 1'b1;
                if (w_last_beat) w_state_nxt = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clk1x_en    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Bytes accumulate in r_shift; data_out only changes once the word is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_last  <= IW'(NREQ - 1);
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_src   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_arb_grant;
                        r_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (w_last_beat) begin
                            r_data <= {r_shift, w_byte};
                            r_src  <= r_grant;
                        end else begin
                            r_shift <= {r_shift[WORD_W-17:0], w_byte};
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_data;
    assign out_src  = r_src;

endmodule

// File: tb/tb_pack_rr_sched.sv
// Randomized and directed bench for pack_rr_sched against a transaction-level reference model.
module tb_pack_rr_sched;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [31:0]      data_out;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_src;
    logic             clk1x_en;

    logic [1:0]       v2;
    logic [15:0]      d2;
    logic [1:0]       rdy2;
    logic [31:0]      do2;
    logic             ov2;
    logic             ordy2;
    logic [0:0]       src2;
    logic             ce2;

    always #5 clk = ~clk;

    pack_rr_sched #(.NREQ(N), .BYTES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .clk1x_en  (clk1x_en)
    );

    pack_rr_sched #(.NREQ(2), .BYTES(4)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v2),
        .req_data  (d2),
        .req_ready (rdy2),
        .data_out  (do2),
        .out_valid (ov2),
        .out_ready (ordy2),
        .out_src   (src2),
        .clk1x_en  (ce2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Reference model: which lane owns the current word, how many bytes it has given, and the pending word.
    bit          m_busy;
    bit          m_emit;
    int          m_lane;
    int          m_got;
    int          m_last;
    logic [31:0] m_word;
    logic [31:0] m_dout;
    int          m_src;

    logic [7:0]  lane_byte [N];
    bit          seq_mode;
    int          obs_src[$];
    int          src2_q[$];
    logic [31:0] last_word;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = lane_byte[i];
    end

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_emit = 0; m_lane = 0; m_got = 0;
        m_last = N - 1; m_word = '0; m_dout = '0; m_src = 0;
    endtask

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        r = '0;
        if (m_busy && !m_emit) r[m_lane] = 1'b1;
        return r;
    endfunction

    task automatic step();
        logic [N-1:0] rdy;
        logic [N-1:0] hs;
        @(negedge clk);
        rdy = m_ready();
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("out_valid", 32'(out_valid), 32'(m_emit));
        check("clk1x_en",  32'(clk1x_en),  32'(m_emit && out_ready));
        check("data_out",  data_out,       m_dout);
        check("out_src",   32'(out_src),   32'(m_src));
        if (clk1x_en) begin
            obs_src.push_back(int'(out_src));
            last_word = data_out;
        end
        if (!rst_n) src2_q.delete();
        else if (ce2) src2_q.push_back(int'(src2));
        @(posedge clk);
        #1;
        if (rst_n) begin
            hs = req_valid & rdy;
            if (m_emit) begin
                if (out_ready) begin
                    m_emit = 0; m_busy = 0; m_last = m_lane;
                end
            end else if (m_busy) begin
                if (req_valid[m_lane]) begin
                    m_word = {m_word[23:0], lane_byte[m_lane]};
                    m_got++;
                    if (m_got == 4) begin
                        m_dout = m_word; m_src = m_lane; m_emit = 1; m_got = 0;
                    end
                end
            end else if (req_valid != '0) begin
                m_lane = rr_pick(req_valid, m_last);
                m_busy = 1; m_got = 0;
            end
            for (int i = 0; i < N; i++)
                if (hs[i]) lane_byte[i] = seq_mode ? lane_byte[i] + 8'h11 : 8'($urandom);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_clk1x_en",  32'(clk1x_en),  32'd0);
        check("rst_data_out",  data_out,       32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        int lat;
        int n0;
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1; seq_mode = 0;
        for (int i = 0; i < N; i++) lane_byte[i] = '0;
        v2 = 2'b11; d2 = 16'hA55A; ordy2 = 1'b1;
        last_word = '0;
        model_reset();
        apply_reset();
        step();

        // Single requester, fixed byte pattern, latency from first valid.
        seq_mode = 1; lane_byte[0] = 8'h11; req_valid = 4'b0001;
        lat = 0; c = 0;
        while (obs_src.size() == 0 && c < 20) begin
            c++;
            step();
            if (obs_src.size() != 0) begin
                lat = c;
                req_valid = '0;
            end
        end
        check("latency", 32'(lat), 32'd6);
        check("word_11223344", last_word, 32'h11223344);
        check("src_single", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd0);
        repeat (6) step();
        check("single_pulse_cnt", 32'(obs_src.size()), 32'd1);

        // All lanes valid: strict rotation starting at 0.
        seq_mode = 0;
        apply_reset();
        obs_src.delete();
        req_valid = '1; out_ready = 1'b1;
        c = 0;
        while (obs_src.size() < 5 && c < 100) begin c++; step(); end
        check("rr_words", 32'(obs_src.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            check("rr_seq", 32'(k < obs_src.size() ? obs_src[k] : -1), 32'(k % 4));
        req_valid = '0;

        // Backpressure: word held 10 cycles with other lanes requesting.
        apply_reset();
        obs_src.delete();
        req_valid = 4'b0001; out_ready = 1'b0;
        c = 0;
        while (!m_emit && c < 20) begin c++; step(); end
        check("bp_reached_emit", 32'(m_emit), 32'd1);
        req_valid = '1;
        repeat (10) step();
        check("bp_no_pulse", 32'(obs_src.size()), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_one_pulse", 32'(obs_src.size()), 32'd1);
        req_valid = '0;
        step();

        // Granted lane stalls mid-word while another lane keeps requesting.
        apply_reset();
        obs_src.delete();
        req_valid = 4'b0010;
        c = 0;
        while (obs_src.size() < 1 && c < 20) begin c++; step(); end
        req_valid = 4'b0110;
        c = 0;
        while (!(m_busy && !m_emit && m_lane == 2 && m_got == 2) && c < 20) begin c++; step(); end
        check("stall_setup", 32'(m_lane), 32'd2);
        req_valid = 4'b0010;
        repeat (5) step();
        req_valid = 4'b0110;
        c = 0;
        while (obs_src.size() < 3 && c < 40) begin c++; step(); end
        check("stall_words", 32'(obs_src.size()), 32'd3);
        check("stall_src_a", 32'(obs_src.size() > 1 ? obs_src[1] : -1), 32'd2);
        check("stall_src_b", 32'(obs_src.size() > 2 ? obs_src[2] : -1), 32'd1);
        req_valid = '0;

        // Reset after three bytes: nothing emitted, lane 0 wins afterwards.
        apply_reset();
        obs_src.delete();
        req_valid = 4'b1000;
        c = 0;
        while (!(m_busy && m_got == 3) && c < 20) begin c++; step(); end
        check("midrst_setup", 32'(m_got), 32'd3);
        req_valid = 4'b1001;
        apply_reset();
        check("midrst_no_word", 32'(obs_src.size()), 32'd0);
        c = 0;
        while (obs_src.size() < 1 && c < 20) begin c++; step(); end
        check("midrst_first_src", 32'(obs_src.size() > 0 ? obs_src[0] : -1), 32'd0);

        // Random traffic and backpressure.
        for (int i = 0; i < 500; i++) begin
            req_valid = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0; out_ready = 1'b1;
        repeat (8) step();

        // Two-requester build: both always valid since the last reset.
        check("n2_words", 32'(src2_q.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++)
            check("n2_alt", 32'(k < src2_q.size() ? src2_q[k] : -1), 32'(k % 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
